// File: rtl/lut_cfg_pkg.sv
// Shared types and constants for the LUT configuration loader.
// One LUT word is the 8-entry truth table of a 3-input LUT PE.
`timescale 1ns/1ps
package lut_cfg_pkg;
  localparam int LUT_W = 8;

  typedef logic [LUT_W-1:0] lut_word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;
endpackage

// File: rtl/lut_cfg_slot.sv
// One PE's configuration slot: a shadow register written by the frame,
// and an active register that only changes when the frame commits.
`timescale 1ns/1ps
module lut_cfg_slot
  import lut_cfg_pkg::*;
(
  input  logic      CLK,
  input  logic      ASYNCRESET,
  input  logic      wr_en,
  input  lut_word_t wr_data,
  input  logic      commit_en,
  output lut_word_t active
);
  lut_word_t shadow_reg;
  lut_word_t active_reg;

  always_ff @(posedge CLK or negedge ASYNCRESET) begin
    if (!ASYNCRESET) begin
      shadow_reg <= '0;
      active_reg <= '0;
    end else begin
      if (wr_en)
        shadow_reg <= wr_data;
      if (commit_en)
        active_reg <= shadow_reg;
    end
  end

  assign active = active_reg;
endmodule

// File: rtl/lut_cfg_loader.sv
// Framed valid/ready loader for the LUT PE array: stages words per PE and
// commits every written PE on the same edge, pausing PE clocks for that cycle.
`timescale 1ns/1ps
module lut_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int ADDR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                    CLK,
  input  logic                    ASYNCRESET,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [ADDR_W-1:0]       cfg_addr,
  input  logic [LUT_W-1:0]        cfg_data,
  input  logic                    cfg_last,
  output logic [LUT_W*NUM_PE-1:0] inst_o,
  output logic                    pe_clk_en,
  output logic                    busy,
  output logic                    cfg_err,
  output logic [7:0]              commit_cnt
);
  cfg_state_t        state_reg, state_next;
  logic              rst_done_reg;
  logic [NUM_PE-1:0] mask_reg, mask_next;
  logic              cfg_err_reg, cfg_err_next;
  logic [7:0]        commit_cnt_reg, commit_cnt_next;
  logic [NUM_PE-1:0] slot_wr;

  logic        beat;
  logic [31:0] addr_ext;
  logic        in_range;

  // Widened so the range test stays meaningful when NUM_PE is a power of two.
  assign addr_ext = 32'(cfg_addr);
  assign in_range = addr_ext < 32'(NUM_PE);
  assign beat     = cfg_valid & cfg_ready;

  always_ff @(posedge CLK or negedge ASYNCRESET) begin
    if (!ASYNCRESET) begin
      state_reg      <= IDLE;
      rst_done_reg   <= 1'b0;
      mask_reg       <= '0;
      cfg_err_reg    <= 1'b0;
      commit_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      rst_done_reg   <= 1'b1;
      mask_reg       <= mask_next;
      cfg_err_reg    <= cfg_err_next;
      commit_cnt_reg <= commit_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    mask_next       = mask_reg;
    cfg_err_next    = cfg_err_reg;
    commit_cnt_next = commit_cnt_reg;
    slot_wr         = '0;

    case (state_reg)
      IDLE:    if (beat) state_next = cfg_last ? COMMIT : LOAD;
      LOAD:    if (beat && cfg_last) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // The first beat of a frame starts a fresh error flag.
    if (beat)
      cfg_err_next = ((state_reg == IDLE) ? 1'b0 : cfg_err_reg) | ~in_range;

    for (int p = 0; p < NUM_PE; p++) begin
      if (beat && in_range && addr_ext == 32'(p)) begin
        slot_wr[p]   = 1'b1;
        mask_next[p] = 1'b1;
      end
    end

    if (state_reg == COMMIT) begin
      mask_next       = '0;
      commit_cnt_next = commit_cnt_reg + 8'd1;
    end
  end

  assign cfg_ready  = rst_done_reg && (state_reg != COMMIT);
  assign pe_clk_en  = rst_done_reg && (state_reg != COMMIT);
  assign busy       = (state_reg != IDLE);
  assign cfg_err    = cfg_err_reg;
  assign commit_cnt = commit_cnt_reg;

  generate
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_slot
      lut_cfg_slot u_slot (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .wr_en      (slot_wr[gi]),
        .wr_data    (cfg_data),
        .commit_en  ((state_reg == COMMIT) && mask_reg[gi]),
        .active     (inst_o[LUT_W*gi +: LUT_W])
      );
    end
  endgenerate
endmodule
